// File: rtl/regdst_hazard_scoreboard_if.sv
// regdst_hazard_scoreboard_if: ID-stage issue/read bundle and hazard results of the destination-register scoreboard
interface regdst_hazard_scoreboard_if;
  logic       issue_valid;
  logic       issue_regwrite;
  logic       issue_isload;
  logic [4:0] issue_write_reg;
  logic       flush;
  logic [4:0] read_rs;
  logic [4:0] read_rt;
  logic       read_rs_used;
  logic       read_rt_used;
  logic       hazard_rs;
  logic       hazard_rt;
  logic       stall;
  logic [5:0] pending_count;
  modport master (
    output issue_valid, issue_regwrite, issue_isload, issue_write_reg, flush,
           read_rs, read_rt, read_rs_used, read_rt_used,
    input  hazard_rs, hazard_rt, stall, pending_count
  );
  modport slave (
    input  issue_valid, issue_regwrite, issue_isload, issue_write_reg, flush,
           read_rs, read_rt, read_rs_used, read_rt_used,
    output hazard_rs, hazard_rt, stall, pending_count
  );
endinterface

// File: rtl/regdst_hazard_scoreboard.sv
// regdst_hazard_scoreboard: per-register countdown of in-flight writes, flags RAW hazards on ID rs/rt and drives stall
// Ports: clk, rst_n (async active-low), sb (slave modport: issue/flush/read in, hazard_rs/hazard_rt/stall/pending_count out).
// Macro FORWARDING_EN: only a load whose result is consumed by the very next instruction is a hazard.
module regdst_hazard_scoreboard #(
  parameter int WB_LATENCY  = 3,
  parameter bit WRITE_FIRST = 1'b1
) (
  input logic                       clk,
  input logic                       rst_n,
  regdst_hazard_scoreboard_if.slave sb
);
  localparam int CW = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(WB_LATENCY);
  localparam logic [CW-1:0] THR = CW'(WRITE_FIRST ? 1 : 0);
  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic [31:0]   ld_q, ld_d, pend;
  logic [5:0]    pending_q, pending_d;
  logic          accept;
  always_comb begin
    for (int r = 0; r < 32; r++)
`ifdef FORWARDING_EN
      pend[r] = ld_q[r] && cnt_q[r] == LAT;
`else
      pend[r] = cnt_q[r] > THR;
`endif
  end
  assign sb.hazard_rs     = sb.read_rs_used && |sb.read_rs && pend[sb.read_rs];
  assign sb.hazard_rt     = sb.read_rt_used && |sb.read_rt && pend[sb.read_rt];
  assign sb.stall         = sb.hazard_rs || sb.hazard_rt;
  assign sb.pending_count = pending_q;
  assign accept = sb.issue_valid && sb.issue_regwrite && !sb.flush && !sb.stall && |sb.issue_write_reg;
  // A fresh issue reloads its register ahead of the decrement, so the newest writer wins.
  always_comb begin
    pending_d = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (accept && sb.issue_write_reg == 5'(r)) ? LAT : (|cnt_q[r] ? cnt_q[r] - 1'b1 : '0);
      ld_d[r] = (accept && sb.issue_write_reg == 5'(r)) ? sb.issue_isload : (ld_q[r] && |cnt_d[r]);
      pending_d = pending_d + 6'(|cnt_d[r]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      ld_q <= '0;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      ld_q <= ld_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_regdst_hazard_scoreboard.sv
// tb_regdst_hazard_scoreboard: random and directed stimulus checked every cycle against a behavioural scoreboard model
module tb_regdst_hazard_scoreboard;
  localparam int LAT = 3;
  localparam int WF  = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mcnt [32];
  bit mld [32];
  int mpc;
  regdst_hazard_scoreboard_if sb();
  regdst_hazard_scoreboard #(.WB_LATENCY(LAT), .WRITE_FIRST(WF)) dut (.clk(clk), .rst_n(rst_n), .sb(sb.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit pend(input int r);
    if (r == 0) return 1'b0;
`ifdef FORWARDING_EN
    return mld[r] && mcnt[r] == LAT;
`else
    return mcnt[r] > (WF ? 1 : 0);
`endif
  endfunction
  function automatic bit ehz_rs();
    return sb.read_rs_used && pend(int'(sb.read_rs));
  endfunction
  function automatic bit ehz_rt();
    return sb.read_rt_used && pend(int'(sb.read_rt));
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        mcnt[r] = 0;
        mld[r] = 0;
      end
      mpc = 0;
    end else begin
      bit acc;
      int w;
      acc = sb.issue_valid && sb.issue_regwrite && !sb.flush && !(ehz_rs() || ehz_rt()) && sb.issue_write_reg != 0;
      w = int'(sb.issue_write_reg);
      for (int r = 0; r < 32; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      if (acc) begin
        mcnt[w] = LAT;
        mld[w] = sb.issue_isload;
      end
      mpc = 0;
      for (int r = 0; r < 32; r++) begin
        if (mcnt[r] == 0) mld[r] = 0;
        else mpc++;
      end
    end
  end
  always @(negedge clk) begin
    chk("hazard_rs", int'(sb.hazard_rs), int'(ehz_rs()));
    chk("hazard_rt", int'(sb.hazard_rt), int'(ehz_rt()));
    chk("stall", int'(sb.stall), int'(ehz_rs() || ehz_rt()));
    chk("pending_count", int'(sb.pending_count), mpc);
  end
  task automatic drive(input bit v, input bit rw, input bit ld, input int wr, input bit fl,
                       input int rs, input int rt, input bit ru, input bit tu);
    sb.issue_valid = v;
    sb.issue_regwrite = rw;
    sb.issue_isload = ld;
    sb.issue_write_reg = 5'(wr);
    sb.flush = fl;
    sb.read_rs = 5'(rs);
    sb.read_rt = 5'(rt);
    sb.read_rs_used = ru;
    sb.read_rt_used = tu;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("reset_pending", int'(sb.pending_count), 0);
    chk("reset_stall", int'(sb.stall), 0);
`ifndef FORWARDING_EN
    drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 9, 0, 8, 0, 1, 0);
    #1 chk("raw_stall_c1", int'(sb.stall), 1);
    chk("raw_pc_c1", int'(sb.pending_count), 1);
    cyc();
    #1 chk("raw_stall_c2", int'(sb.stall), 1);
    chk("gated_pc_c2", int'(sb.pending_count), 1);
    cyc();
    #1 chk("raw_stall_c3", int'(sb.stall), 0);
    cyc();
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
    #1 chk("r9_issued_pc", int'(sb.pending_count), 1);
    cyc();
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 4, 4, 1, 1);
    #1 chk("rewrite_rs", int'(sb.hazard_rs), 1);
    chk("rewrite_rt", int'(sb.hazard_rt), 1);
    cyc();
    #1 chk("rewrite_stall2", int'(sb.stall), 1);
    cyc();
    #1 chk("rewrite_stall3", int'(sb.stall), 0);
`else
    drive(1, 1, 1, 10, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 11, 0, 0, 10, 0, 1);
    #1 chk("load_use_stall1", int'(sb.stall), 1);
    cyc();
    #1 chk("load_use_stall2", int'(sb.stall), 0);
    cyc();
    drive(1, 1, 0, 12, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 12, 0, 1, 0);
    #1 chk("alu_use_stall", int'(sb.stall), 0);
`endif
    cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("r0_stall", int'(sb.stall), 0);
    cyc();
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 5, 0, 1, 0);
    #1 chk("pre_reset_stall", int'(sb.stall), 1);
    rst_n = 1'b0;
    #1 chk("mid_reset_stall", int'(sb.stall), 0);
    chk("mid_reset_pc", int'(sb.pending_count), 0);
    cyc();
    rst_n = 1'b1;
    #1 chk("post_reset_rs5", int'(sb.hazard_rs), 0);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 9) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (i % 500 == 250) begin
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
